// File: rtl/project_pkg.sv
// Shared core types: machine word, architectural register names, write-back entry.
package project_pkg;

  localparam int word_size = 8;
  localparam int reg_size  = 2;

  typedef logic [word_size-1:0] word;
  typedef enum logic [reg_size-1:0] {R0, R1, R2, R3} e_reg;

  typedef struct packed {
    e_reg rd;
    word  data;
  } wb_entry_t;

  typedef enum logic {GRANT_ALU, GRANT_MEM} e_grant;

endpackage

// File: rtl/wb_fifo.sv
// Dual-push single-pop circular buffer of write-back entries; push0 lands before push1.
// Exposes head pointer and raw storage so the parent can search pending entries.
module wb_fifo
  import project_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push0,
  input  wb_entry_t din0,
  input  logic      push1,
  input  wb_entry_t din1,
  input  logic      pop,
  output wb_entry_t head,
  output wb_entry_t entries [DEPTH],
  output logic [PW-1:0] head_ptr,
  output logic [CW-1:0] count
);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] tail_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push0) mem[tail_ptr] <= din0;
      // a lone push1 takes the tail slot itself
      if (push1) mem[tail_ptr + PW'(push0)] <= din1;
      tail_ptr <= tail_ptr + PW'(push0) + PW'(push1);
      if (pop) head_ptr <= head_ptr + PW'(1);
      count <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

  assign head = mem[head_ptr];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) entries[i] = mem[i];
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: arbitrates ALU/mem results into an in-order FIFO, retires one per cycle.
// Optional pending-value bypass lookup under WB_BYPASS_EN; stalls a source only when the FIFO is full.
module wb_stage
  import project_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  e_reg          alu_reg,
  input  word           alu_data,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  e_reg          mem_reg,
  input  word           mem_data,
  output logic          rf_wr_en,
  output e_reg          rf_wr_addr,
  output word           rf_wr_data,
  input  e_reg          byp_addr1,
  input  e_reg          byp_addr2,
  output logic          byp_hit1,
  output logic          byp_hit2,
  output word           byp_data1,
  output word           byp_data2,
  output logic [CW-1:0] count
);

  localparam logic [CW:0] FULL = (CW + 1)'(DEPTH);

  wb_entry_t     head;
  wb_entry_t     entries [DEPTH];
  logic [PW-1:0] head_ptr;
  logic          pop;
  logic [CW:0]   free;
  e_grant        last_grant;
  logic          mem_wins;
  logic          contention;
  logic          alu_fire;
  logic          mem_fire;

  assign pop  = (count != '0) && !rst;
  assign free = FULL - {1'b0, count} + (CW + 1)'(pop);

  // With one slot, a lone requester wins; on contention the source not granted last time wins.
  assign mem_wins = alu_valid ? (mem_valid && last_grant == GRANT_ALU)
                              : (mem_valid || last_grant == GRANT_ALU);

  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (!rst) begin
      if (free >= (CW + 1)'(2)) begin
        alu_ready = 1'b1;
        mem_ready = 1'b1;
      end else if (free == (CW + 1)'(1)) begin
        alu_ready = !mem_wins;
        mem_ready = mem_wins;
      end
    end
  end

  assign alu_fire   = alu_valid && alu_ready;
  assign mem_fire   = mem_valid && mem_ready;
  assign contention = !rst && alu_valid && mem_valid && (free == (CW + 1)'(1));

  always_ff @(posedge clk) begin
    if (rst)             last_grant <= GRANT_ALU;
    else if (contention) last_grant <= mem_wins ? GRANT_MEM : GRANT_ALU;
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push0    (mem_fire),
    .din0     ('{rd: mem_reg, data: mem_data}),
    .push1    (alu_fire),
    .din1     ('{rd: alu_reg, data: alu_data}),
    .pop      (pop),
    .head     (head),
    .entries  (entries),
    .head_ptr (head_ptr),
    .count    (count)
  );

  assign rf_wr_en   = pop;
  assign rf_wr_addr = pop ? head.rd : R0;
  assign rf_wr_data = pop ? head.data : '0;

`ifdef WB_BYPASS_EN
  e_reg byp_addr [2];
  logic byp_hit  [2];
  word  byp_data [2];

  assign byp_addr[0] = byp_addr1;
  assign byp_addr[1] = byp_addr2;

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      byp_hit[p]  = 1'b0;
      byp_data[p] = '0;
      if (!rst) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (CW'(k) < count && entries[head_ptr + PW'(k)].rd == byp_addr[p]) begin
            byp_hit[p]  = 1'b1;
            byp_data[p] = entries[head_ptr + PW'(k)].data;
          end
        end
      end
    end
  end

  assign byp_hit1  = byp_hit[0];
  assign byp_hit2  = byp_hit[1];
  assign byp_data1 = byp_data[0];
  assign byp_data2 = byp_data[1];
`else
  assign byp_hit1  = 1'b0;
  assign byp_hit2  = 1'b0;
  assign byp_data1 = '0;
  assign byp_data2 = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed plus randomized bench for wb_stage against a queue-based reference model.
module tb_wb_stage;
  import project_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst;
  logic          alu_valid, mem_valid;
  logic          alu_ready, mem_ready;
  e_reg          alu_reg, mem_reg, byp_addr1, byp_addr2, rf_wr_addr;
  word           alu_data, mem_data, rf_wr_data, byp_data1, byp_data2;
  logic          rf_wr_en, byp_hit1, byp_hit2;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  wb_entry_t q[$];
  bit        last_alu;

  wb_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .byp_addr1(byp_addr1), .byp_addr2(byp_addr2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic av, input e_reg ar, input word ad,
                       input logic mv, input e_reg mr, input word md);
    rst = r;
    alu_valid = av; alu_reg = ar; alu_data = ad;
    mem_valid = mv; mem_reg = mr; mem_data = md;
  endtask

  function automatic logic [word_size:0] model_byp(input e_reg a);
    logic [word_size:0] r;
    r = '0;
`ifdef WB_BYPASS_EN
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].rd == a) begin
        r = {1'b1, q[i].data};
        break;
      end
    end
`endif
    return r;
  endfunction

  // One cycle: inputs already driven after a negedge; check outputs, advance model, clock.
  task automatic step();
    bit pop, ea, em, chk_rdy;
    int free;
    logic [word_size:0] b1, b2;
    #1;
    if (rst) begin
      check("rst_wr_en", rf_wr_en, 0);
      check("rst_wr_addr", rf_wr_addr, 0);
      check("rst_wr_data", rf_wr_data, 0);
      check("rst_alu_ready", alu_ready, 0);
      check("rst_mem_ready", mem_ready, 0);
      check("rst_hit1", byp_hit1, 0);
      check("rst_hit2", byp_hit2, 0);
      q.delete();
      last_alu = 1'b1;
    end else begin
      pop = (q.size() != 0);
      check("wr_en", rf_wr_en, pop);
      check("wr_addr", rf_wr_addr, pop ? q[0].rd : R0);
      check("wr_data", rf_wr_data, pop ? q[0].data : '0);
      check("count", count, q.size());
      b1 = model_byp(byp_addr1);
      b2 = model_byp(byp_addr2);
      check("hit1", byp_hit1, b1[word_size]);
      check("data1", byp_data1, b1[word_size-1:0]);
      check("hit2", byp_hit2, b2[word_size]);
      check("data2", byp_data2, b2[word_size-1:0]);
      free = DEPTH - q.size() + (pop ? 1 : 0);
      chk_rdy = 1'b1;
      ea = 1'b1; em = 1'b1;
      if (free < 2) begin
        if (alu_valid && mem_valid) begin em = last_alu; ea = !last_alu; end
        else if (alu_valid)         begin em = 1'b0; ea = 1'b1; end
        else if (mem_valid)         begin em = 1'b1; ea = 1'b0; end
        else chk_rdy = 1'b0;
      end
      if (chk_rdy) begin
        check("alu_ready", alu_ready, ea);
        check("mem_ready", mem_ready, em);
      end
      if (pop) void'(q.pop_front());
      if (mem_valid && em) q.push_back('{rd: mem_reg, data: mem_data});
      if (alu_valid && ea) q.push_back('{rd: alu_reg, data: alu_data});
      if (alu_valid && mem_valid && free == 1) last_alu = ea;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, R0, '0, 1'b0, R0, '0);
  endtask

  initial begin
    q.delete();
    last_alu = 1'b1;
    byp_addr1 = R0; byp_addr2 = R0;
    drive(1'b1, 1'b0, R0, '0, 1'b0, R0, '0);
    @(negedge clk);
    step(); step();

    // Idle after reset
    idle();
    #1;
    check("idle_alu_ready", alu_ready, 1);
    check("idle_mem_ready", mem_ready, 1);
    step();

    // Single ALU push r2 = AA
    drive(1'b0, 1'b1, R2, 8'hAA, 1'b0, R0, '0);
    step();
    idle();
    #1;
    check("single_en", rf_wr_en, 1);
    check("single_addr", rf_wr_addr, R2);
    check("single_data", rf_wr_data, 8'hAA);
    step();
    check("single_count", count, 0);
    step();

    // Dual push for six cycles, then drain
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, R3, word'(8'h20 + i), 1'b1, R1, word'(8'h10 + i));
      step();
    end
    idle();
    for (int i = 0; i < DEPTH + 2; i++) step();

    // Same-register ordering with bypass on r0
    byp_addr1 = R0; byp_addr2 = R1;
    drive(1'b0, 1'b1, R0, 8'h22, 1'b1, R0, 8'h11);
    step();
    idle();
    for (int i = 0; i < 3; i++) step();

    // Bypass visibility of r3 = DD
    drive(1'b0, 1'b1, R3, 8'hDD, 1'b0, R0, '0);
    step();
    idle();
    byp_addr1 = R3; byp_addr2 = R0;
    #1;
`ifdef WB_BYPASS_EN
    check("byp_dd_hit1", byp_hit1, 1);
    check("byp_dd_data1", byp_data1, 8'hDD);
`else
    check("byp_dd_hit1", byp_hit1, 0);
    check("byp_dd_data1", byp_data1, 0);
`endif
    check("byp_dd_hit2", byp_hit2, 0);
    check("byp_dd_data2", byp_data2, 0);
    step();
    step();

    // Fill to count=3, then reset mid-operation
    drive(1'b0, 1'b1, R1, 8'h51, 1'b1, R2, 8'h52);
    step();
    drive(1'b0, 1'b1, R3, 8'h53, 1'b1, R0, 8'h54);
    step();
    check("pre_rst_count", count, 3);
    drive(1'b1, 1'b0, R0, '0, 1'b0, R0, '0);
    step();
    idle();
    check("post_rst_count", count, 0);
    for (int i = 0; i < 3; i++) step();

    // Randomized traffic with occasional reset
    for (int n = 0; n < 500; n++) begin
      drive(($urandom_range(0, 59) == 0),
            ($urandom_range(0, 9) < 7), e_reg'($urandom_range(0, 3)), word'($urandom),
            ($urandom_range(0, 9) < 7), e_reg'($urandom_range(0, 3)), word'($urandom));
      byp_addr1 = e_reg'($urandom_range(0, 3));
      byp_addr2 = e_reg'($urandom_range(0, 3));
      step();
    end
    idle();
    for (int i = 0; i < DEPTH + 2; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage directly upstream of the register file. Accepts results from the ALU and memory paths through valid/ready handshakes, buffers them in order in a small FIFO, and retires one entry per cycle onto the register-file write port. Optionally exposes a bypass lookup so operand fetch sees values that are still pending write-back.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle when alu_valid && alu_ready
- alu_reg  in  e_reg  ALU destination register
- alu_data  in  word  ALU result
- mem_valid  in  1  memory result offered
- mem_ready  out  1  memory result accepted when mem_valid && mem_ready
- mem_reg  in  e_reg  memory destination register
- mem_data  in  word  memory result
- rf_wr_en  out  1  register-file write enable
- rf_wr_addr  out  e_reg  register-file write address
- rf_wr_data  out  word  register-file write data
- byp_addr1, byp_addr2  in  e_reg  bypass lookup addresses
- byp_hit1, byp_hit2  out  1  pending entry exists for that address
- byp_data1, byp_data2  out  word  data of youngest matching pending entry
- count  out  $clog2(DEPTH+1)  entries pending

## Operation
- Pop: whenever count≠0 and !rst, the head entry drives rf_wr_*, with rf_wr_en=1, and is removed at the clock edge. The register file never stalls.
- free = DEPTH − count + (count≠0 ? 1 : 0). This counts the slots available this cycle, including the one freed by the pop.
- free≥2: alu_ready = mem_ready = 1.
- free==1: only the arbitration winner is ready. Arbitration is round-robin on a last_grant flag, which updates only on contention cycles (both valid, free==1).
- free==0: both ready = 0. This occurs only at count==DEPTH during rst.
- Both pushes in one cycle: the mem entry is enqueued first (older), then the alu entry.
- Order is strictly FIFO. Repeated writes to the same register retire in enqueue order.
- count_next = count + pushes − pop. pushes ranges 0..2; pop is 0 or 1.
- Bypass: a combinational search over stored entries only. Same-cycle inputs are not searched. The youngest match wins. No match gives hit=0 and data=0.
- Reset: pointers=0, count=0, last_grant=ALU (so mem wins the first contention), all stored entries cleared.
  - During rst, rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, all ready=0 and hit=0.
  - Reset mid-operation discards all pending entries without writing them.

## Timing
- Latency: a result accepted at edge N appears on rf_wr_* during cycle N+1 if the FIFO was empty, and is written into the register file at edge N+1.
- Each older pending entry adds one cycle.
- A value is visible through bypass from cycle N+1 until the cycle of its rf write. From edge N+1+k onward the register file holds it.
- ready depends only on registered state and the same-cycle valids. There is no ready→valid loop.
- Sustained throughput is 1 write per cycle. The dual-push excess fills the FIFO, after which one source stalls.

## Configuration
- WB_BYPASS_EN defined: the bypass search logic is present as described.
- WB_BYPASS_EN undefined: byp_hit*=0 and byp_data*=0 constant, and the search logic is removed. Operand fetch must stall on pending writes, using count≠0.

## Structure
- project_pkg gains typedef wb_entry_t (struct: e_reg rd; word data), reusing existing word, e_reg, word_size and reg_size.
- Sub-module wb_fifo has a dual-push, single-pop circular buffer of wb_entry_t with count, head output and entry-array output for the bypass search.
- wb_stage contains the arbitration, ready generation, reset gating and bypass search.

## Test plan
- Reset then idle: count=0, rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, both ready=1, byp_hit*=0.
- Single ALU push r2=8'hAA at edge N: rf_wr_en=1, addr=2, data=AA in cycle N+1; count returns to 0 after edge N+1.
- Dual push each cycle for 6 cycles (mem r1=8'h10+i, alu r3=8'h20+i):
  - writes alternate mem/alu in order;
  - count saturates at DEPTH;
  - thereafter exactly one source is ready per cycle, alternating;
  - no data is lost or duplicated.
- Same-register ordering: push mem r0=8'h11 and alu r0=8'h22 together. r0 is written 11 then 22. Bypass on r0 returns 22 while both are pending, then 22 after 11 retires.
- With WB_BYPASS_EN: push r3=8'hDD, query byp_addr1=3, byp_addr2=0 next cycle. Response hit1=1, data1=DD, hit2=0, data2=0. Without the macro, hit1=0.
- Assert rst with count=3: no rf write occurs in the reset cycle. After reset, count=0 and the discarded entries never appear on rf_wr_*.
